// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing, arbiter state encoding.
package uart_pkg;

  localparam int UART_BYTE_W         = 8;
  localparam int CYC_PER_BIT         = 5208;
  // Comfortably longer than one 10-bit frame at CYC_PER_BIT.
  localparam int DEFAULT_TIMEOUT_CYC = 60000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after index
// `last`, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the candidates in rotation order; keep the first hit.
  always_comb begin
    valid   = |req;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = IDX_W'((int'(last) + i) % NUM_REQ);
      idx     = (req[cand_s] && !found_s) ? cand_s : idx;
      found_s = found_s | req[cand_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional watchdog abort of a stuck transfer: define UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
`ifdef UART_TX_TIMEOUT_EN
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
`endif
  parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [UART_BYTE_W-1:0]         tx_data_o,
  output logic                           tx_start_o,
  input  logic                           tx_done_i,
  output logic                           busy_o,
  output logic [IDX_W-1:0]               grant_idx_o,
  output logic                           timeout_o
);

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    for (int k = 0; k < NUM_REQ; k++) begin
      v[k] = (idx == IDX_W'(k));
    end
    return v;
  endfunction

  arb_state_e             state_r;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       grant_r;
  logic [UART_BYTE_W-1:0] tx_data_r;
  logic                   tx_start_r;
  logic [NUM_REQ-1:0]     ack_r;
  logic                   busy_r;

  logic                   pick_valid_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [UART_BYTE_W-1:0] pick_byte_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_i),
    .last  (last_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Byte lane of the arbitration winner.
  always_comb begin
    pick_byte_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_byte_s = (pick_idx_s == IDX_W'(k)) ? data_i[k*UART_BYTE_W +: UART_BYTE_W] : pick_byte_s;
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;
`endif

  // Arbitration / transmit handshake FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      last_r     <= IDX_W'(NUM_REQ - 1);
      grant_r    <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      ack_r      <= '0;
      busy_r     <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
      cnt_r      <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      ack_r <= '0;
`ifdef UART_TX_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          // A done still high from the previous frame blocks a new grant.
          if (pick_valid_s && !tx_done_i) begin
            tx_data_r <= pick_byte_s;
            grant_r   <= pick_idx_s;
            last_r    <= pick_idx_s;
            busy_r    <= 1'b1;
            state_r   <= START;
`ifdef UART_TX_TIMEOUT_EN
            cnt_r     <= '0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          tx_start_r <= 1'b1;
          state_r    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            tx_start_r <= 1'b0;
            ack_r      <= idx_to_onehot(grant_r);
            state_r    <= RELEASE;
`ifdef UART_TX_TIMEOUT_EN
          end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Abort without ack; last_r already points at this requester,
            // so the others are served before it retries.
            tx_start_r <= 1'b0;
            timeout_r  <= 1'b1;
            state_r    <= RELEASE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
`else
          end else begin
            state_r <= WAIT_DONE;
          end
`endif
        end
        RELEASE: begin
          if (!tx_done_i) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= RELEASE;
          end
        end
        default: begin
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_r;
  assign tx_data_o   = tx_data_r;
  assign tx_start_o  = tx_start_r;
  assign busy_o      = busy_r;
  assign grant_idx_o = grant_r;
`ifdef UART_TX_TIMEOUT_EN
  assign timeout_o   = timeout_r;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Timeout scenario is exercised only when UART_TX_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic [15:0]        data;
  logic [NUM_REQ-1:0] ack;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done;
  logic               busy;
  logic [IDX_W-1:0]   grant;
  logic               timeout;

  logic model_en;
  logic model_done;
  logic force_done;
  int   mcnt;
  int   done_delay = 10;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign tx_done = model_done | force_done;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
`ifdef UART_TX_TIMEOUT_EN
    .TIMEOUT_CYC (100),
`endif
    .IDX_W       (IDX_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .data_i      (data),
    .ack_o       (ack),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_done_i   (tx_done),
    .busy_o      (busy),
    .grant_idx_o (grant),
    .timeout_o   (timeout)
  );

  // Transmitter model: raise done done_delay cycles after start, drop it once start drops.
  always @(posedge clk) begin
    if (!model_en || !tx_start) begin
      mcnt       <= 0;
      model_done <= 1'b0;
    end else if (!model_done) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == done_delay) model_done <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer: latency to start, start-high cycles, latched data/grant,
  // ack and timeout at the falling start edge, and ack one cycle later.
  task automatic run_xfer(input int max_cyc, input logic late_chg,
                          output int lat, output int hi, output logic [7:0] d0,
                          output logic stable, output logic [IDX_W-1:0] g,
                          output logic [1:0] ack_v, output logic to_v,
                          output logic [1:0] ack_n, output logic ack_mid,
                          output logic ok);
    logic started;
    started = 1'b0; ok = 1'b0; lat = 0; hi = 0; d0 = 8'h00; stable = 1'b1;
    g = '0; ack_v = 2'b00; to_v = 1'b0; ack_n = 2'b00; ack_mid = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (!started) begin
        lat++;
        if (tx_start) begin
          started = 1'b1;
          hi      = 1;
          d0      = tx_data;
          g       = grant;
          ack_mid = ack_mid | (ack != 2'b00);
        end
      end else if (tx_start) begin
        hi++;
        ack_mid = ack_mid | (ack != 2'b00);
        if (tx_data !== d0) stable = 1'b0;
        if (late_chg && hi == 3) data[7:0] = 8'h5A;
      end else begin
        ack_v = ack;
        to_v  = timeout;
        @(negedge clk);
        ack_n = ack;
        ok    = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int               lat, hi;
  logic [7:0]       d0;
  logic             stable, to_v, ack_mid, ok;
  logic [IDX_W-1:0] g;
  logic [1:0]       ack_v, ack_n;

  initial begin
    rst_n = 1'b0; req = 2'b00; data = 16'h0000; model_en = 1'b1; force_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_start", tx_start, 1'b0);
    check_val("rst_ack", ack, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_grant", grant, 1'b0);
    check_val("rst_tx_data", tx_data, 8'h00);
    check_val("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request with a late data change during WAIT_DONE.
    req = 2'b01; data = 16'h0041;
    run_xfer(60, 1'b1, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
    check_val("single_done", ok, 1'b1);
    check_val("single_latency", lat, 2);
    check_val("single_data", d0, 8'h41);
    check_val("late_chg_stable", stable, 1'b1);
    check_val("single_grant", g, 1'b0);
    check_val("single_start_cycles", hi, 11);
    check_val("single_ack", ack_v, 2'b01);
    check_val("single_ack_once", ack_n, 2'b00);
    check_val("single_no_early_ack", ack_mid, 1'b0);
    check_val("single_no_timeout", to_v, 1'b0);
    check_val("late_chg_hold", tx_data, 8'h41);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check_val("single_idle_busy", busy, 1'b0);

    // Reset asserted while waiting for done.
    req = 2'b01; data = 16'h0041;
    repeat (5) @(negedge clk);
    check_val("midrst_pre_start", tx_start, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_start_drop", tx_start, 1'b0);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ack", ack, 2'b00);
    check_val("midrst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(60, 1'b0, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
    check_val("midrst_redo_done", ok, 1'b1);
    check_val("midrst_redo_latency", lat, 2);
    check_val("midrst_redo_ack", ack_v, 2'b01);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Contention: both requesting, strict alternation from requester 0.
    pulse_reset();
    req = 2'b11; data = 16'h6261;
    for (int t = 0; t < 4; t++) begin
      run_xfer(60, 1'b0, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
      check_val($sformatf("cont%0d_done", t), ok, 1'b1);
      check_val($sformatf("cont%0d_data", t), d0, (t % 2 == 0) ? 8'h61 : 8'h62);
      check_val($sformatf("cont%0d_grant", t), g, (t % 2 == 0) ? 1'b0 : 1'b1);
      check_val($sformatf("cont%0d_ack", t), ack_v, (t % 2 == 0) ? 2'b01 : 2'b10);
      check_val($sformatf("cont%0d_ack_once", t), ack_n, 2'b00);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Stale done blocks the grant until it drops.
    force_done = 1'b1; req = 2'b01; data = 16'h0033;
    repeat (5) @(negedge clk);
    check_val("stale_busy", busy, 1'b0);
    check_val("stale_start", tx_start, 1'b0);
    force_done = 1'b0;
    run_xfer(60, 1'b0, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
    check_val("stale_done", ok, 1'b1);
    check_val("stale_latency", lat, 2);
    check_val("stale_data", d0, 8'h33);
    check_val("stale_ack", ack_v, 2'b01);
    req = 2'b00;
    repeat (3) @(negedge clk);

`ifdef UART_TX_TIMEOUT_EN
    // Transmitter never answers: abort after 100 cycles, then serve requester 1.
    pulse_reset();
    model_en = 1'b0; req = 2'b11; data = 16'h6261;
    run_xfer(300, 1'b0, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
    check_val("to_done", ok, 1'b1);
    check_val("to_start_cycles", hi, 100);
    check_val("to_pulse", to_v, 1'b1);
    check_val("to_no_ack", ack_v, 2'b00);
    check_val("to_grant", g, 1'b0);
    check_val("to_pulse_once", timeout, 1'b0);
    model_en = 1'b1;
    run_xfer(60, 1'b0, lat, hi, d0, stable, g, ack_v, to_v, ack_n, ack_mid, ok);
    check_val("to_next_done", ok, 1'b1);
    check_val("to_next_grant", g, 1'b1);
    check_val("to_next_data", d0, 8'h62);
    check_val("to_next_ack", ack_v, 2'b10);
    req = 2'b00;
    repeat (3) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
